// File: rtl/micro_sequencer_pkg.sv
// Shared types, widths, control-word layout and micro-ROM contents for the micro-sequencer.
package micro_pkg;

    localparam int unsigned CTRL_W        = 19;
    localparam int unsigned UADDR_W       = 5;
    localparam int unsigned DEF_DEPTH     = 24;
    localparam int unsigned DEF_WAIT_ADDR = 18;

    typedef enum logic [1:0] {
        BUS_NONE    = 2'd0,
        BUS_ADDR_RD = 2'd1,
        BUS_ADDR_WR = 2'd2,
        BUS_DATA    = 2'd3
    } bus_attr_e;

    typedef struct packed {
        bus_attr_e           attr;
        logic [CTRL_W-1:0]   ctrl;
    } uentry_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_e;

    // Entry points of each instruction class
    localparam logic [UADDR_W-1:0] UA_LW    = 5'd0;
    localparam logic [UADDR_W-1:0] UA_SW    = 5'd2;
    localparam logic [UADDR_W-1:0] UA_RTYPE = 5'd4;
    localparam logic [UADDR_W-1:0] UA_ITYPE = 5'd8;
    localparam logic [UADDR_W-1:0] UA_LUI   = 5'd12;
    localparam logic [UADDR_W-1:0] UA_JAL   = 5'd14;
    localparam logic [UADDR_W-1:0] UA_JALR  = 5'd16;
    localparam logic [UADDR_W-1:0] UA_WAIT  = 5'd18;
    localparam logic [UADDR_W-1:0] UA_BNE   = 5'd19;
    localparam logic [UADDR_W-1:0] UA_BLTU  = 5'd21;
    localparam logic [UADDR_W-1:0] UA_SPARE = 5'd23;

    // Control-word bit positions
    localparam int unsigned CW_LAST       = 0;
    localparam int unsigned CW_PC_WE      = 1;
    localparam int unsigned CW_SRC_A_PC   = 2;
    localparam int unsigned CW_SRC_B_IMM  = 3;
    localparam int unsigned CW_ALU_OP     = 4;   // 3-bit field
    localparam int unsigned CW_MEM_TO_REG = 7;
    localparam int unsigned CW_BRANCH     = 8;
    localparam int unsigned CW_BR_NE      = 9;
    localparam int unsigned CW_BR_LTU     = 10;
    localparam int unsigned CW_JUMP       = 11;
    localparam int unsigned CW_LINK       = 12;
    localparam int unsigned CW_IMM_SEL    = 13;  // 3-bit field
    localparam int unsigned CW_ADDR_SEL   = 16;
    localparam int unsigned CW_CMP_WE     = 17;
    localparam int unsigned CW_RF_WE      = CTRL_W - 1;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_SLTU = 3'd3;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    function automatic logic [CTRL_W-1:0] cw_bit(input int unsigned pos);
        return CTRL_W'(1) << pos;
    endfunction

    function automatic logic [CTRL_W-1:0] cw_alu(input logic [2:0] op);
        return CTRL_W'(op) << CW_ALU_OP;
    endfunction

    function automatic logic [CTRL_W-1:0] cw_imm(input logic [2:0] sel);
        return CTRL_W'(sel) << CW_IMM_SEL;
    endfunction

    // Micro-ROM contents; unlisted addresses hold the terminal wait word
    function automatic uentry_t rom_entry(input logic [UADDR_W-1:0] a);
        uentry_t e;
        e.attr = BUS_NONE;
        e.ctrl = cw_bit(CW_LAST);
        case (a)
            UA_LW: begin
                e.attr = BUS_ADDR_RD;
                e.ctrl = cw_bit(CW_SRC_B_IMM) | cw_bit(CW_ADDR_SEL) | cw_imm(IMM_I) | cw_alu(ALU_ADD);
            end
            5'd1: begin
                e.attr = BUS_DATA;
                e.ctrl = cw_bit(CW_MEM_TO_REG) | cw_bit(CW_RF_WE) | cw_bit(CW_LAST);
            end
            UA_SW: begin
                e.attr = BUS_ADDR_WR;
                e.ctrl = cw_bit(CW_SRC_B_IMM) | cw_bit(CW_ADDR_SEL) | cw_imm(IMM_S);
            end
            5'd3: begin
                e.attr = BUS_DATA;
                e.ctrl = cw_bit(CW_LAST);
            end
            UA_RTYPE: e.ctrl = cw_bit(CW_RF_WE) | cw_bit(CW_LAST);
            UA_ITYPE: e.ctrl = cw_bit(CW_SRC_B_IMM) | cw_imm(IMM_I) | cw_bit(CW_RF_WE) | cw_bit(CW_LAST);
            UA_LUI:   e.ctrl = cw_bit(CW_SRC_B_IMM) | cw_imm(IMM_U) | cw_bit(CW_RF_WE) | cw_bit(CW_LAST);
            UA_JAL:   e.ctrl = cw_bit(CW_SRC_A_PC) | cw_bit(CW_LINK) | cw_bit(CW_RF_WE);
            5'd15:    e.ctrl = cw_bit(CW_SRC_A_PC) | cw_bit(CW_SRC_B_IMM) | cw_imm(IMM_J)
                             | cw_bit(CW_JUMP) | cw_bit(CW_PC_WE) | cw_bit(CW_LAST);
            UA_JALR:  e.ctrl = cw_bit(CW_SRC_B_IMM) | cw_bit(CW_CMP_WE);
            5'd17:    e.ctrl = cw_bit(CW_LINK) | cw_bit(CW_RF_WE) | cw_bit(CW_JUMP)
                             | cw_bit(CW_PC_WE) | cw_bit(CW_LAST);
            UA_WAIT:  e.ctrl = cw_bit(CW_LAST);
            UA_BNE:   e.ctrl = cw_alu(ALU_SUB) | cw_bit(CW_CMP_WE);
            5'd20:    e.ctrl = cw_bit(CW_SRC_A_PC) | cw_bit(CW_SRC_B_IMM) | cw_imm(IMM_B)
                             | cw_bit(CW_BRANCH) | cw_bit(CW_BR_NE) | cw_bit(CW_PC_WE) | cw_bit(CW_LAST);
            UA_BLTU:  e.ctrl = cw_alu(ALU_SLTU) | cw_bit(CW_CMP_WE);
            5'd22:    e.ctrl = cw_bit(CW_SRC_A_PC) | cw_bit(CW_SRC_B_IMM) | cw_imm(IMM_B)
                             | cw_bit(CW_BRANCH) | cw_bit(CW_BR_LTU) | cw_bit(CW_PC_WE) | cw_bit(CW_LAST);
            // Diagnostic spare: writes the register file but never terminates, so it ends by run-off
            UA_SPARE: e.ctrl = cw_bit(CW_RF_WE);
            default:  e.ctrl = cw_bit(CW_LAST);
        endcase
        return e;
    endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// Decode hand-off and AHB-Lite control signals between the sequencer and its environment.
interface micro_sequencer_if;
    import micro_pkg::*;

    logic [UADDR_W-1:0] decode_addr;
    logic               id_rf_valid_inst;
    logic               HREADY;
    logic               HRESP;
    logic [1:0]         HTRANS;
    logic               HWRITE;
    logic [CTRL_W-1:0]  current_control;
    logic               stall;
    logic               done;
    logic               rf_valid_inst;
    logic               bus_err;
    logic               illegal;

    modport master (
        input  decode_addr, id_rf_valid_inst, HREADY, HRESP,
        output HTRANS, HWRITE, current_control, stall, done, rf_valid_inst, bus_err, illegal
    );

    modport slave (
        output decode_addr, id_rf_valid_inst, HREADY, HRESP,
        input  HTRANS, HWRITE, current_control, stall, done, rf_valid_inst, bus_err, illegal
    );
endinterface

// File: rtl/micro_sequencer_rom.sv
// Combinational micro-ROM; reads at or beyond DEPTH return the wait entry.
module micro_rom
    import micro_pkg::*;
#(
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned WAIT_ADDR = DEF_WAIT_ADDR
) (
    input  logic [UADDR_W-1:0] addr_i,
    output uentry_t            entry_o
);

    // Bounded lookup into the constant table
    always_comb begin
        if (32'(addr_i) < DEPTH) begin
            entry_o = rom_entry(addr_i);
        end else begin
            entry_o = rom_entry(UADDR_W'(WAIT_ADDR));
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Micro-PC sequencer: zero-latency entry, single-outstanding AHB transfers, error and fault termination.
module micro_sequencer
    import micro_pkg::*;
#(
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned WAIT_ADDR = DEF_WAIT_ADDR
) (
    input  logic                clk,
    input  logic                rst,
    micro_sequencer_if.master   bus
);

    localparam logic [UADDR_W-1:0] WAIT_UA = UADDR_W'(WAIT_ADDR);

    seq_state_e         state_q, state_d;
    logic [UADDR_W-1:0] upc_q, upc_d;
    logic [UADDR_W-1:0] ea;
    logic [UADDR_W:0]   ea_inc;
    logic               entry_bad;
    uentry_t            ent;

    logic [1:0]         htrans_c;
    logic               hwrite_c;
    logic [CTRL_W-1:0]  ctrl_c;
    logic               stall_c;
    logic               done_c;
    logic               rfv_c;
    logic               berr_c;
    logic               ill_c;

    micro_rom #(
        .DEPTH     (DEPTH),
        .WAIT_ADDR (WAIT_ADDR)
    ) u_rom (
        .addr_i  (ea),
        .entry_o (ent)
    );

    // Effective micro-address: decoded entry in IDLE, uPC in RUN, wait entry on reset or bad entry
    always_comb begin
        entry_bad = 1'b0;
        ea        = WAIT_UA;
        if (!rst) begin
            if (state_q == ST_RUN) begin
                ea = upc_q;
            end else if (bus.id_rf_valid_inst) begin
                if (32'(bus.decode_addr) >= DEPTH) begin
                    entry_bad = 1'b1;
                end else begin
                    ea = bus.decode_addr;
                end
            end
        end
    end

    // Step outputs and advance decision
    always_comb begin
        ea_inc   = {1'b0, ea} + (UADDR_W+1)'(1);
        state_d  = state_q;
        upc_d    = upc_q;
        htrans_c = 2'b00;
        hwrite_c = 1'b0;
        ctrl_c   = ent.ctrl;
        stall_c  = 1'b0;
        done_c   = 1'b0;
        rfv_c    = 1'b0;
        berr_c   = 1'b0;
        ill_c    = entry_bad;

        if (ent.attr == BUS_ADDR_RD || ent.attr == BUS_ADDR_WR) begin
            htrans_c = 2'b10;
            hwrite_c = (ent.attr == BUS_ADDR_WR);
        end

        if (!rst) begin
            if (ent.attr == BUS_DATA && !bus.HREADY) begin
                stall_c          = 1'b1;
                ctrl_c[CW_RF_WE] = 1'b0;
            end else if (ent.attr == BUS_DATA && bus.HRESP) begin
                ctrl_c[CW_RF_WE] = 1'b0;
                berr_c           = 1'b1;
                done_c           = 1'b1;
                rfv_c            = 1'b1;
                state_d          = ST_IDLE;
                upc_d            = WAIT_UA;
            end else if (ent.ctrl[CW_LAST]) begin
                done_c  = 1'b1;
                rfv_c   = !entry_bad && (state_q == ST_RUN || bus.id_rf_valid_inst);
                state_d = ST_IDLE;
                upc_d   = WAIT_UA;
            end else if (32'(ea_inc) >= DEPTH) begin
                done_c  = 1'b1;
                rfv_c   = 1'b1;
                ill_c   = 1'b1;
                state_d = ST_IDLE;
                upc_d   = WAIT_UA;
            end else begin
                upc_d   = ea_inc[UADDR_W-1:0];
                state_d = ST_RUN;
            end
        end
    end

    // State and micro-PC registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            upc_q   <= WAIT_UA;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
        end
    end

    assign bus.HTRANS          = htrans_c;
    assign bus.HWRITE          = hwrite_c;
    assign bus.current_control = ctrl_c;
    assign bus.stall           = stall_c;
    assign bus.done            = done_c;
    assign bus.rf_valid_inst   = rfv_c;
    assign bus.bus_err         = berr_c;
    assign bus.illegal         = ill_c;

endmodule
